// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: state and owner encodings and the
// RAM read-latency bound check.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    // Wide enough to hold LAT_MAX.
    localparam int LAT_W   = 3;

    function automatic bit ram_lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/arb_rdata_hold.sv
// Per-port read return: pulses valid in the return cycle, passes the RAM
// word straight through that cycle and holds it afterwards.
module arb_rdata_hold (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ret,
    input  logic [31:0] i_rdata,
    output logic        o_valid,
    output logic [31:0] o_rdata
);

    logic [31:0] r_hold;

    // Capture the returned word so the port keeps it until the next return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (i_ret) begin
            r_hold <= i_rdata;
        end
    end

    assign o_valid = i_ret;
    assign o_rdata = i_ret ? i_rdata : r_hold;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the core's fetch port
// (imem_*) and data port (mem_*). Data-first arbitration with a starvation
// guard that forces a fetch after STARVE_MAX data grants while a fetch waits.
// One read outstanding at a time.
// Optional: define MEM_ARBITER_PERF_EN to add perf_dstall / perf_istall
// stall-cycle counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 16,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   imem_addr,
    input  logic          imem_oe,
    output logic [31:0]   imem_rdata,
    output logic          imem_valid,
    input  logic [31:0]   mem_addr,
    input  logic          mem_oe,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_we,
    output logic [31:0]   mem_rdata,
    output logic          mem_valid,
    output logic          mem_ready,
    output logic [AW-1:0] ram_addr,
    output logic          ram_oe,
    output logic [3:0]    ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]   perf_dstall,
    output logic [31:0]   perf_istall
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    if (!ram_lat_ok(RAM_LAT)) begin : g_bad_lat
        $error("mem_arbiter: RAM_LAT must be in 1..4");
    end

    arb_state_e       r_state, w_state_nx;
    arb_owner_e       r_owner, w_owner_nx;
    logic [LAT_W-1:0] r_lat, w_lat_nx;
    logic             r_ipend;
    logic [15:0]      r_ipaddr;
    logic [SW-1:0]    r_starve;

    logic             w_force_i;
    logic             w_gnt_d;
    logic             w_gnt_i;
    logic             w_ret;
    logic [15:0]      w_iaddr;
    logic [31:0]      w_iaddr_ext;

    assign w_force_i   = r_ipend && (r_starve == SW'(STARVE_MAX));
    // Registered state only, so the core's stall logic cannot loop through us.
    assign mem_ready   = (r_state == IDLE) && !w_force_i;
    assign w_iaddr     = r_ipend ? r_ipaddr : imem_addr;
    assign w_iaddr_ext = {16'h0000, w_iaddr};

    // Grant decision, RAM strobes and next-state for the single-owner FSM.
    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_lat_nx   = r_lat;
        w_gnt_d    = 1'b0;
        w_gnt_i    = 1'b0;
        w_ret      = 1'b0;
        ram_addr   = '0;
        ram_oe     = 1'b0;
        ram_we     = 4'b0000;
        ram_wdata  = 32'h0;
        if (r_state == IDLE) begin
            if (mem_oe && !w_force_i) begin
                w_gnt_d   = 1'b1;
                ram_addr  = mem_addr[AW-1:0];
                ram_oe    = 1'b1;
                ram_we    = mem_we;
                ram_wdata = mem_wdata;
                // Stores retire in the grant cycle; only loads occupy the RAM.
                if (mem_we == 4'b0000) begin
                    w_state_nx = BUSY;
                    w_owner_nx = OWN_D;
                    w_lat_nx   = LAT_W'(RAM_LAT);
                end
            end else if (r_ipend || imem_oe) begin
                w_gnt_i    = 1'b1;
                ram_addr   = w_iaddr_ext[AW-1:0];
                ram_oe     = 1'b1;
                w_state_nx = BUSY;
                w_owner_nx = OWN_I;
                w_lat_nx   = LAT_W'(RAM_LAT);
            end
        end else begin
            w_lat_nx = r_lat - 1'b1;
            if (r_lat == LAT_W'(1)) begin
                w_ret      = 1'b1;
                w_state_nx = IDLE;
            end
        end
    end

    // FSM state register; reset abandons any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
            r_lat   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_lat   <= w_lat_nx;
        end
    end

    // Pending-fetch latch (last request wins) and starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ipend  <= 1'b0;
            r_ipaddr <= 16'h0000;
            r_starve <= '0;
        end else begin
            // A live fetch is consumed only when it is the one being granted.
            if (imem_oe && !(w_gnt_i && !r_ipend)) begin
                r_ipend  <= 1'b1;
                r_ipaddr <= imem_addr;
            end else if (w_gnt_i) begin
                r_ipend <= 1'b0;
            end
            if (w_gnt_i) begin
                r_starve <= '0;
            end else if (w_gnt_d && r_ipend && (r_starve != SW'(STARVE_MAX))) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    arb_rdata_hold u_hold_i (
        .clk     (clk),
        .rst     (rst),
        .i_ret   (w_ret && (r_owner == OWN_I)),
        .i_rdata (ram_rdata),
        .o_valid (imem_valid),
        .o_rdata (imem_rdata)
    );

    arb_rdata_hold u_hold_d (
        .clk     (clk),
        .rst     (rst),
        .i_ret   (w_ret && (r_owner == OWN_D)),
        .i_rdata (ram_rdata),
        .o_valid (mem_valid),
        .o_rdata (mem_rdata)
    );

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] r_perf_d;
    logic [31:0] r_perf_i;

    // Stall-cycle counters; free-running, wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_d <= 32'h0;
            r_perf_i <= 32'h0;
        end else begin
            if (mem_oe && !mem_ready) begin
                r_perf_d <= r_perf_d + 32'd1;
            end
            if (r_ipend && !w_gnt_i) begin
                r_perf_i <= r_perf_i + 32'd1;
            end
        end
    end

    assign perf_dstall = r_perf_d;
    assign perf_istall = r_perf_i;
`endif

    // Address bits above the RAM window are intentionally dropped.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, mem_addr[31:AW], w_iaddr_ext[31:AW]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int AW         = 16;
    localparam int RAM_LAT    = 3;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   imem_addr = '0;
    logic          imem_oe = 1'b0;
    logic [31:0]   imem_rdata;
    logic          imem_valid;
    logic [31:0]   mem_addr = '0;
    logic          mem_oe = 1'b0;
    logic [31:0]   mem_wdata = '0;
    logic [3:0]    mem_we = '0;
    logic [31:0]   mem_rdata;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] ram_addr;
    logic          ram_oe;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0]   perf_dstall;
    logic [31:0]   perf_istall;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .RAM_LAT(RAM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_oe    (imem_oe),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .mem_addr   (mem_addr),
        .mem_oe     (mem_oe),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .ram_addr   (ram_addr),
        .ram_oe     (ram_oe),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef MEM_ARBITER_PERF_EN
        ,
        .perf_dstall(perf_dstall),
        .perf_istall(perf_istall)
`endif
    );

    // Physical RAM: 256 words, read data appears RAM_LAT cycles after ram_oe.
    logic [31:0] ram [256];
    logic [31:0] pipe [RAM_LAT];
    assign ram_rdata = pipe[RAM_LAT-1];

    always @(posedge clk) begin
        for (int i = RAM_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= $urandom;
        if (ram_oe) begin
            if (ram_we == 4'b0000) begin
                pipe[0] <= ram[ram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: a read finishes at a known cycle number,
    // a waiting fetch is one slot, and the model memory is read at grant time.
    logic [31:0]  m_mem [256];
    bit           m_busy, m_own_i, m_ipend, m_dstall;
    int unsigned  m_done, cyc;
    int           m_starve;
    logic [31:0]  m_exp, m_ih, m_dh;
    logic [15:0]  m_ipaddr;
    logic [31:0]  m_pd, m_pi;

    always @(negedge clk) begin
        bit          ret, gd, gi, force_i, rdy;
        logic [15:0] ia;
        logic [AW-1:0] ea;
        if (!rst) begin
            m_busy = 0; m_own_i = 0; m_ipend = 0; m_dstall = 0; m_starve = 0;
            m_ih = '0; m_dh = '0; m_pd = '0; m_pi = '0; m_ipaddr = '0;
            chk("rst_imem_valid", imem_valid, 0);
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_imem_rdata", imem_rdata, 0);
            chk("rst_mem_rdata", mem_rdata, 0);
            chk("rst_ram_oe", ram_oe, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_mem_ready", mem_ready, 1);
        end else begin
            ret     = m_busy && (cyc == m_done);
            force_i = m_ipend && (m_starve == STARVE_MAX);
            rdy     = !m_busy && !force_i;
            gd      = rdy && mem_oe;
            gi      = !m_busy && !gd && (m_ipend || imem_oe);
            ia      = m_ipend ? m_ipaddr : imem_addr;
            ea      = gd ? mem_addr[AW-1:0] : (gi ? ia : '0);

            chk("mem_ready", mem_ready, rdy);
            chk("ram_oe", ram_oe, gd || gi);
            chk("ram_addr", ram_addr, ea);
            chk("ram_we", ram_we, gd ? mem_we : 4'b0000);
            if (gd && mem_we != 4'b0000) chk("ram_wdata", ram_wdata, mem_wdata);
            chk("imem_valid", imem_valid, ret && m_own_i);
            chk("mem_valid", mem_valid, ret && !m_own_i);
            chk("imem_rdata", imem_rdata, (ret && m_own_i) ? m_exp : m_ih);
            chk("mem_rdata", mem_rdata, (ret && !m_own_i) ? m_exp : m_dh);
`ifdef MEM_ARBITER_PERF_EN
            chk("perf_dstall", perf_dstall, m_pd);
            chk("perf_istall", perf_istall, m_pi);
            m_pd = m_pd + ((mem_oe && !rdy) ? 32'd1 : 32'd0);
            m_pi = m_pi + ((m_ipend && !gi) ? 32'd1 : 32'd0);
`endif
            if (ret) begin
                m_busy = 0;
                if (m_own_i) m_ih = m_exp; else m_dh = m_exp;
            end
            if (gd) begin
                if (mem_we != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_we[b]) m_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    m_busy = 1; m_own_i = 0; m_done = cyc + RAM_LAT;
                    m_exp = m_mem[mem_addr[9:2]];
                end
                if (m_ipend && m_starve < STARVE_MAX) m_starve++;
            end
            if (gi) begin
                m_busy = 1; m_own_i = 1; m_done = cyc + RAM_LAT;
                m_exp = m_mem[ia[9:2]];
                m_starve = 0;
            end
            if (imem_oe && !(gi && !m_ipend)) begin
                m_ipend = 1; m_ipaddr = imem_addr;
            end else if (gi) begin
                m_ipend = 0;
            end
            m_dstall = mem_oe && !rdy;
        end
        cyc++;
    end

    task automatic drive(input bit ioe, input logic [15:0] ia, input bit doe,
                         input logic [31:0] da, input logic [3:0] we, input logic [31:0] wd);
        imem_oe = ioe; imem_addr = ia;
        mem_oe = doe; mem_addr = da; mem_we = we; mem_wdata = wd;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, '0, '0, '0);
    endtask

    initial begin
        logic [31:0] da;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            m_mem[i] = ram[i];
        end
        for (int i = 0; i < RAM_LAT; i++) pipe[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Lone fetch, then the hold register keeps the word.
        drive(1, 16'h0010, 0, '0, '0, '0);
        idle(RAM_LAT + 3);

        // Collision: load wins, fetch waits in the pending slot.
        drive(1, 16'h0020, 1, 32'h0000_0100, 4'b0000, '0);
        idle(2 * RAM_LAT + 3);

        // Store with a fetch alongside: store retires at once, fetch next cycle.
        drive(1, 16'h0030, 1, 32'h0000_0200, 4'b0011, 32'hDEAD_BEEF);
        idle(RAM_LAT + 3);
        drive(0, '0, 1, 32'h0000_0200, 4'b0000, '0);
        idle(RAM_LAT + 2);

        // Starvation: fetch pending while loads arrive back to back.
        drive(0, '0, 1, 32'h0000_0040, 4'b0000, '0);
        drive(1, 16'h0044, 1, 32'h0000_0048, 4'b0000, '0);
        da = 32'h0000_0048;
        for (int i = 0; i < 40; i++) begin
            if (!m_dstall) da = {16'h0, 6'h0, 8'($urandom), 2'b00};
            drive(0, '0, 1, da, 4'b0000, '0);
        end
        idle(RAM_LAT + 3);

        // Reset while a load is in flight: no return may follow.
        drive(0, '0, 1, 32'h0000_0300, 4'b0000, '0);
        imem_oe = 0; mem_oe = 0; rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(RAM_LAT + 3);

        // Random traffic; the core holds a stalled data request unchanged.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                imem_oe = 0; mem_oe = 0; rst = 1'b0;
                idle(2);
                rst = 1'b1;
            end else if (m_dstall) begin
                drive(($urandom_range(0, 3) == 0), 16'($urandom), 1, mem_addr, mem_we, mem_wdata);
            end else begin
                drive(($urandom_range(0, 3) == 0), 16'($urandom),
                      ($urandom_range(0, 1) == 0), $urandom,
                      ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                      $urandom);
            end
        end
        idle(RAM_LAT + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
